instruction_fetch: RTL

Fetch sequencer that sits directly upstream of the register-select/decode stage of the datapath. On request from the control unit it reads the word addressed by the program counter from memory through a ready/valid handshake, latches it into the instruction register, and advances or redirects the PC. It then holds the IR stable with a valid flag until the decode stage acknowledges it.

---
 rtl/instruction_fetch.sv | 120 ++++++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch sequencer: PC-addressed memory read into IR with ready/valid handshake
// Holds the IR with a valid flag until decode acks; branches during a fetch are deferred to its completion.
module instruction_fetch #(
  parameter int ADDR_W   = 9,
  parameter int MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              branch_load,
  input  logic [31:0]       branch_target,
  input  logic              mem_ready,
  input  logic [31:0]       mem_data_in,
  input  logic              ir_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic [31:0]       pc,
  output logic [31:0]       ir,
  output logic              ir_valid,
  output logic              busy,
  output logic              fetch_err
);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, HOLD} state_t;

  // The timeout fires on the MAX_WAIT-th consecutive WAIT edge without mem_ready.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state;
  state_t      next_state;
  logic [7:0]  wait_cnt;
  logic        br_pend;
  logic [31:0] br_tgt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        wait_expired;

  always_ff @(posedge clk) begin
    if (!clr) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = ADDR;
      ADDR: next_state = WAIT;
      WAIT: begin
        if (mem_ready)         next_state = HOLD;
        else if (wait_expired) next_state = IDLE;
      end
      HOLD: if (ir_ack) next_state = start ? ADDR : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A branch arriving on the completing edge itself wins over an older pending one.
  always_comb begin
    busy           = (state == ADDR) || (state == WAIT);
    wait_expired   = (wait_cnt == WAIT_LAST);
    redirect_valid = branch_load || br_pend;
    redirect_pc    = branch_load ? branch_target : br_tgt;
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      pc        <= '0;
      ir        <= '0;
      ir_valid  <= 1'b0;
      mem_read  <= 1'b0;
      mem_addr  <= '0;
      fetch_err <= 1'b0;
      wait_cnt  <= '0;
      br_pend   <= 1'b0;
      br_tgt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (branch_load) pc <= branch_target;
          if (start)       fetch_err <= 1'b0;
        end
        ADDR: begin
          mem_addr <= pc[ADDR_W-1:0];
          mem_read <= 1'b1;
          wait_cnt <= '0;
          if (branch_load) begin
            br_pend <= 1'b1;
            br_tgt  <= branch_target;
          end
        end
        WAIT: begin
          if (mem_ready) begin
            ir       <= mem_data_in;
            ir_valid <= 1'b1;
            mem_read <= 1'b0;
            pc       <= redirect_valid ? redirect_pc : pc + 32'd1;
            br_pend  <= 1'b0;
          end else if (wait_expired) begin
            fetch_err <= 1'b1;
            mem_read  <= 1'b0;
            br_pend   <= 1'b0;
            if (redirect_valid) pc <= redirect_pc;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (branch_load) begin
              br_pend <= 1'b1;
              br_tgt  <= branch_target;
            end
          end
        end
        HOLD: begin
          if (branch_load) pc <= branch_target;
          if (ir_ack)      ir_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
